desc_window: RTL and testbench

DESC_WINDOW -- requirements
Module: desc_window

---
 rtl/desc_pkg.sv | 22 ++
 rtl/desc_cmp3.sv | 13 +
 rtl/desc_window.sv | 129 ++++++++++++
 tb/tb_desc_window.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/desc_pkg.sv
// Shared types and constants for the descending-window detector.
package desc_pkg;

  localparam int SAMPLE_W = 3;

  typedef enum logic [1:0] {
    FILL_EMPTY = 2'd0,
    FILL_ONE   = 2'd1,
    FILL_TWO   = 2'd2,
    FILL_FULL  = 2'd3
  } fill_e;

  // Fill progression on one accepted sample; FULL is absorbing.
  function automatic fill_e fill_next(input fill_e s);
    case (s)
      FILL_EMPTY: fill_next = FILL_ONE;
      FILL_ONE:   fill_next = FILL_TWO;
      default:    fill_next = FILL_FULL;
    endcase
  endfunction

endpackage

// File: rtl/desc_cmp3.sv
// Strict three-way descending comparison: hit when a > b > c (unsigned).
module desc_cmp3
  import desc_pkg::*;
(
  input  logic [SAMPLE_W-1:0] a,
  input  logic [SAMPLE_W-1:0] b,
  input  logic [SAMPLE_W-1:0] c,
  output logic                hit
);

  assign hit = (a > b) && (b > c);

endmodule

// File: rtl/desc_window.sv
// Sliding 3-sample window with a registered strictly-decreasing flag and a
// saturating count of hits taken by downstream.
module desc_window
  import desc_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                in_valid,
  input  logic [SAMPLE_W-1:0] in_data,
  output logic                in_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_hit,
  output logic [SAMPLE_W-1:0] out_a,
  output logic [SAMPLE_W-1:0] out_b,
  output logic [SAMPLE_W-1:0] out_c,
  output logic [CNT_W-1:0]    hit_count
);

  // Handshakes: a transfer happens on a side only in a cycle where its valid
  // and ready are both 1; a held result never changes until it transfers.

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  fill_e               fill_q, fill_d;
  logic [SAMPLE_W-1:0] win_a_q, win_a_d;
  logic [SAMPLE_W-1:0] win_b_q, win_b_d;
  logic [SAMPLE_W-1:0] win_c_q, win_c_d;
  logic                out_valid_q, out_valid_d;
  logic                out_hit_q, out_hit_d;
  logic [SAMPLE_W-1:0] out_a_q, out_a_d;
  logic [SAMPLE_W-1:0] out_b_q, out_b_d;
  logic [SAMPLE_W-1:0] out_c_q, out_c_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic ready;
  logic accept;
  logic out_fire;
  logic result_new;
  logic cmp_hit;

  desc_cmp3 u_cmp (
    .a   (win_a_d),
    .b   (win_b_d),
    .c   (win_c_d),
    .hit (cmp_hit)
  );

  always_comb begin
    ready      = (!out_valid_q || out_ready) && !clear;
    accept     = in_valid && ready;
    // clear suppresses the output handshake so no hit is counted that cycle
    out_fire   = out_valid_q && out_ready && !clear;
    result_new = accept && (fill_q == FILL_TWO || fill_q == FILL_FULL);

    fill_d  = fill_q;
    win_a_d = win_a_q;
    win_b_d = win_b_q;
    win_c_d = win_c_q;
    if (clear) begin
      fill_d = FILL_EMPTY;
    end else if (accept) begin
      fill_d  = fill_next(fill_q);
      win_a_d = win_b_q;
      win_b_d = win_c_q;
      win_c_d = in_data;
    end

    out_valid_d = out_valid_q;
    out_hit_d   = out_hit_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    out_c_d     = out_c_q;
    if (clear) begin
      out_valid_d = 1'b0;
    end else if (result_new) begin
      out_valid_d = 1'b1;
      out_hit_d   = cmp_hit;
      out_a_d     = win_a_d;
      out_b_d     = win_b_d;
      out_c_d     = win_c_d;
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end

    cnt_d = cnt_q;
    if (out_fire && out_hit_q && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_q      <= FILL_EMPTY;
      win_a_q     <= '0;
      win_b_q     <= '0;
      win_c_q     <= '0;
      out_valid_q <= 1'b0;
      out_hit_q   <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_c_q     <= '0;
      cnt_q       <= '0;
    end else begin
      fill_q      <= fill_d;
      win_a_q     <= win_a_d;
      win_b_q     <= win_b_d;
      win_c_q     <= win_c_d;
      out_valid_q <= out_valid_d;
      out_hit_q   <= out_hit_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      out_c_q     <= out_c_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready  = ready;
  assign out_valid = out_valid_q;
  assign out_hit   = out_hit_q;
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign out_c     = out_c_q;
  assign hit_count = cnt_q;

endmodule

// File: tb/tb_desc_window.sv
// Directed table-driven bench for desc_window (CNT_W=2 to reach saturation).
module tb_desc_window;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             clear = 1'b0;
  logic             in_valid = 1'b0;
  logic [2:0]       in_data = 3'd0;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             out_hit;
  logic [2:0]       out_a, out_b, out_c;
  logic [CNT_W-1:0] hit_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  desc_window #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_hit   (out_hit),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_c     (out_c),
    .hit_count (hit_count)
  );

  typedef struct {
    logic       rst;
    logic       clr;
    logic       v;
    logic [2:0] d;
    logic       r;
    logic       rdy;
    logic       ov;
    logic       hit;
    logic [2:0] a;
    logic [2:0] b;
    logic [2:0] c;
    int         cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rs, input logic cl, input logic v,
                              input int d, input logic r, input logic rdy,
                              input logic ov, input logic hit, input int a,
                              input int b, input int c, input int cnt);
    vec_t t;
    t.rst = rs; t.clr = cl; t.v = v; t.d = 3'(d); t.r = r; t.rdy = rdy;
    t.ov = ov; t.hit = hit; t.a = 3'(a); t.b = 3'(b); t.c = 3'(c); t.cnt = cnt;
    return t;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one row, check in_ready before the edge, check outputs after it.
  task automatic apply(input vec_t t, input int idx);
    rst       = t.rst;
    clear     = t.clr;
    in_valid  = t.v;
    in_data   = t.d;
    out_ready = t.r;
    #1;
    chk($sformatf("row%0d in_ready", idx), int'(in_ready), int'(t.rdy));
    @(posedge clk);
    #1;
    chk($sformatf("row%0d out_valid", idx), int'(out_valid), int'(t.ov));
    chk($sformatf("row%0d hit_count", idx), int'(hit_count), t.cnt);
    if (t.ov) begin
      chk($sformatf("row%0d out_hit", idx), int'(out_hit), int'(t.hit));
      chk($sformatf("row%0d abc", idx), int'({out_a, out_b, out_c}),
          int'({t.a, t.b, t.c}));
    end
  endtask

  initial begin
    // fill and equality/slide
    tbl.push_back(mk(1,0,0,0,1, 1, 0,0,0,0,0, 0));
    tbl.push_back(mk(0,0,1,7,1, 1, 0,0,0,0,0, 0));
    tbl.push_back(mk(0,0,1,5,1, 1, 0,0,0,0,0, 0));
    tbl.push_back(mk(0,0,1,2,1, 1, 1,1,7,5,2, 0));
    tbl.push_back(mk(0,0,1,2,1, 1, 1,0,5,2,2, 1));
    tbl.push_back(mk(0,0,1,1,1, 1, 1,0,2,2,1, 1));
    tbl.push_back(mk(0,0,0,0,1, 1, 0,0,0,0,0, 1));
    // backpressure: held for 5 cycles, then back-to-back
    tbl.push_back(mk(0,0,1,0,0, 1, 1,1,2,1,0, 1));
    tbl.push_back(mk(0,0,1,7,0, 0, 1,1,2,1,0, 1));
    tbl.push_back(mk(0,0,1,3,0, 0, 1,1,2,1,0, 1));
    tbl.push_back(mk(0,0,1,6,0, 0, 1,1,2,1,0, 1));
    tbl.push_back(mk(0,0,1,4,0, 0, 1,1,2,1,0, 1));
    tbl.push_back(mk(0,0,1,5,0, 0, 1,1,2,1,0, 1));
    tbl.push_back(mk(0,0,1,7,1, 1, 1,0,1,0,7, 2));
    tbl.push_back(mk(0,0,1,6,1, 1, 1,0,0,7,6, 2));
    tbl.push_back(mk(0,0,0,0,1, 1, 0,0,0,0,0, 2));
    // clear: coincident out_ready not counted, then clear during TWO
    tbl.push_back(mk(0,0,1,5,0, 1, 1,1,7,6,5, 2));
    tbl.push_back(mk(0,1,1,0,1, 0, 0,0,0,0,0, 2));
    tbl.push_back(mk(0,0,1,6,1, 1, 0,0,0,0,0, 2));
    tbl.push_back(mk(0,0,1,5,1, 1, 0,0,0,0,0, 2));
    tbl.push_back(mk(0,1,1,4,1, 0, 0,0,0,0,0, 2));
    tbl.push_back(mk(0,0,1,4,1, 1, 0,0,0,0,0, 2));
    tbl.push_back(mk(0,0,1,3,1, 1, 0,0,0,0,0, 2));
    tbl.push_back(mk(0,0,1,1,1, 1, 1,1,4,3,1, 2));
    tbl.push_back(mk(0,0,0,0,1, 1, 0,0,0,0,0, 3));
    // saturation from a fresh reset: 7,6,5,4,3,2,1
    tbl.push_back(mk(1,0,0,0,1, 1, 0,0,0,0,0, 0));
    tbl.push_back(mk(0,0,1,7,1, 1, 0,0,0,0,0, 0));
    tbl.push_back(mk(0,0,1,6,1, 1, 0,0,0,0,0, 0));
    tbl.push_back(mk(0,0,1,5,1, 1, 1,1,7,6,5, 0));
    tbl.push_back(mk(0,0,1,4,1, 1, 1,1,6,5,4, 1));
    tbl.push_back(mk(0,0,1,3,1, 1, 1,1,5,4,3, 2));
    tbl.push_back(mk(0,0,1,2,1, 1, 1,1,4,3,2, 3));
    tbl.push_back(mk(0,0,1,1,1, 1, 1,1,3,2,1, 3));
    tbl.push_back(mk(0,0,0,0,1, 1, 0,0,0,0,0, 3));
    // pending hit result ahead of the async reset sequence
    tbl.push_back(mk(0,0,1,0,0, 1, 1,1,2,1,0, 3));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // async reset between edges while a result is held
    #2;
    rst = 1'b1;
    #1;
    chk("async out_valid", int'(out_valid), 0);
    chk("async hit_count", int'(hit_count), 0);
    chk("async out_hit", int'(out_hit), 0);
    chk("async abc", int'({out_a, out_b, out_c}), 0);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    apply(mk(0,0,1,7,1, 1, 0,0,0,0,0, 0), 100);
    apply(mk(0,0,1,5,1, 1, 0,0,0,0,0, 0), 101);
    apply(mk(0,0,1,2,1, 1, 1,1,7,5,2, 0), 102);
    apply(mk(0,0,0,0,1, 1, 0,0,0,0,0, 1), 103);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
